// File: rtl/sram_arbiter.sv
// Arbiter for the single external 16-bit SRAM shared by the CPU data port (A),
// the instruction-fetch port (B) and the video fetch port (V).
module sram_arbiter #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2,
  parameter int STARVE      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reqA,
  input  logic              weA,
  input  logic [ADDR_W-1:0] addrA,
  input  logic [DATA_W-1:0] wdataA,
  output logic              ackA,
  output logic [DATA_W-1:0] rdataA,
  input  logic              reqB,
  input  logic [ADDR_W-1:0] addrB,
  output logic              ackB,
  output logic [DATA_W-1:0] rdataB,
  input  logic              reqV,
  input  logic [ADDR_W-1:0] addrV,
  output logic              ackV,
  output logic [DATA_W-1:0] rdataV,
  output logic [1:0]        owner,
  inout  wire  [DATA_W-1:0] memDataBus,
  output logic [ADDR_W-1:0] memAddrBus,
  output logic              memRead,
  output logic              memWrite,
  output logic              memEnable
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int SC_W  = $clog2(STARVE + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(STARVE);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_A    = 2'd1;
  localparam logic [1:0] OWN_B    = 2'd2;
  localparam logic [1:0] OWN_V    = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } stateT;

  stateT             state;
  stateT             stateNext;
  logic [1:0]        grant;
  logic [ADDR_W-1:0] grantAddr;
  logic              grantWe;
  logic [DATA_W-1:0] grantData;
  logic              weR;
  logic              dataOe;
  logic [DATA_W-1:0] dataOut;
  logic [CNT_W-1:0]  waitCnt;
  logic [SC_W-1:0]   starveCnt;
  logic              lastAccess;
  logic              granting;

  assign memDataBus = dataOe ? dataOut : {DATA_W{1'bz}};
  assign lastAccess = (state == ACCESS) && (waitCnt == WAIT_LAST);
  assign granting   = (state == IDLE) && (grant != OWN_NONE);

  // Arbitration, access sequencing and winner field selection
  always_comb begin
    stateNext = state;
    grant     = OWN_NONE;
    grantAddr = memAddrBus;
    grantWe   = 1'b0;
    grantData = dataOut;
    case (state)
      IDLE: begin
        // A starved video port overrides the fixed A > B > V order
        if (reqV && (starveCnt >= STARVE_MAX)) begin
          grant = OWN_V;
        end else if (reqA) begin
          grant = OWN_A;
        end else if (reqB) begin
          grant = OWN_B;
        end else if (reqV) begin
          grant = OWN_V;
        end else begin
          grant = OWN_NONE;
        end
        if (grant != OWN_NONE) begin
          stateNext = SETUP;
        end else begin
          stateNext = IDLE;
        end
      end
      SETUP:  stateNext = ACCESS;
      ACCESS: begin
        if (waitCnt == WAIT_LAST) begin
          stateNext = DONE;
        end else begin
          stateNext = ACCESS;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    case (grant)
      OWN_A: begin
        grantAddr = addrA;
        grantWe   = weA;
        grantData = wdataA;
      end
      OWN_B: begin
        grantAddr = addrB;
        grantWe   = 1'b0;
        grantData = {DATA_W{1'b0}};
      end
      OWN_V: begin
        grantAddr = addrV;
        grantWe   = 1'b0;
        grantData = {DATA_W{1'b0}};
      end
      default: begin
        grantAddr = memAddrBus;
        grantWe   = 1'b0;
        grantData = dataOut;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // SRAM pin drive, ownership, wait and starvation counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner      <= OWN_NONE;
      weR        <= 1'b0;
      dataOe     <= 1'b0;
      dataOut    <= {DATA_W{1'b0}};
      memAddrBus <= {ADDR_W{1'b0}};
      memRead    <= 1'b1;
      memWrite   <= 1'b1;
      memEnable  <= 1'b1;
      waitCnt    <= {CNT_W{1'b0}};
      starveCnt  <= {SC_W{1'b0}};
    end else begin
      if (granting) begin
        owner      <= grant;
        weR        <= grantWe;
        dataOe     <= grantWe;
        dataOut    <= grantData;
        memAddrBus <= grantAddr;
        memEnable  <= 1'b0;
        memRead    <= grantWe;
        if (grant == OWN_V) begin
          starveCnt <= {SC_W{1'b0}};
        end else if (reqV && (starveCnt < STARVE_MAX)) begin
          starveCnt <= starveCnt + 1'b1;
        end
      end
      if (state == SETUP) begin
        memWrite <= ~weR;
      end
      if (lastAccess) begin
        memEnable <= 1'b1;
        memRead   <= 1'b1;
        memWrite  <= 1'b1;
      end
      // Write data stays on the bus through DONE as hold time
      if (state == DONE) begin
        owner  <= OWN_NONE;
        dataOe <= 1'b0;
      end
      if ((state == ACCESS) && !lastAccess) begin
        waitCnt <= waitCnt + 1'b1;
      end else begin
        waitCnt <= {CNT_W{1'b0}};
      end
    end
  end

  // Completion pulses and read data capture on the final ACCESS edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ackA   <= 1'b0;
      ackB   <= 1'b0;
      ackV   <= 1'b0;
      rdataA <= {DATA_W{1'b0}};
      rdataB <= {DATA_W{1'b0}};
      rdataV <= {DATA_W{1'b0}};
    end else begin
      ackA <= lastAccess && (owner == OWN_A);
      ackB <= lastAccess && (owner == OWN_B);
      ackV <= lastAccess && (owner == OWN_V);
      if (lastAccess && !weR && (owner == OWN_A)) begin
        rdataA <= memDataBus;
      end
      if (lastAccess && (owner == OWN_B)) begin
        rdataB <= memDataBus;
      end
      if (lastAccess && (owner == OWN_V)) begin
        rdataV <= memDataBus;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: a behavioural SRAM model on the pins,
// expected acks queued by the stimulus and checked by a negedge monitor.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        reqA, weA, reqB, reqV;
  logic [17:0] addrA, addrB, addrV;
  logic [15:0] wdataA;
  logic        ackA, ackB, ackV;
  logic [15:0] rdataA, rdataB, rdataV;
  logic [1:0]  owner;
  wire  [15:0] memDataBus;
  logic [17:0] memAddrBus;
  logic        memRead, memWrite, memEnable;

  sram_arbiter dut (
    .clk(clk), .rst(rst),
    .reqA(reqA), .weA(weA), .addrA(addrA), .wdataA(wdataA), .ackA(ackA), .rdataA(rdataA),
    .reqB(reqB), .addrB(addrB), .ackB(ackB), .rdataB(rdataB),
    .reqV(reqV), .addrV(addrV), .ackV(ackV), .rdataV(rdataV),
    .owner(owner), .memDataBus(memDataBus), .memAddrBus(memAddrBus),
    .memRead(memRead), .memWrite(memWrite), .memEnable(memEnable)
  );

  // SRAM model: preloaded during reset, drives reads, captures writes
  logic [15:0] mem [0:262143];
  logic        modelDrv;
  assign modelDrv   = !memEnable && !memRead;
  assign memDataBus = modelDrv ? mem[memAddrBus] : 16'hzzzz;
  always @(posedge clk) begin
    if (!rst) begin
      mem[18'h00100] <= 16'hBEEF;
      mem[18'h00200] <= 16'hCAFE;
    end else if (!memEnable && !memWrite) begin
      mem[memAddrBus] <= memDataBus;
    end
  end

  // Second instance with a one-cycle access phase and a constant-data SRAM
  logic        reqA1, weA1, reqB1, reqV1;
  logic [17:0] addrA1, addrB1, addrV1;
  logic [15:0] wdataA1;
  logic        ackA1, ackB1, ackV1;
  logic [15:0] rdataA1, rdataB1, rdataV1;
  logic [1:0]  owner1;
  wire  [15:0] memDataBus1;
  logic [17:0] memAddrBus1;
  logic        memRead1, memWrite1, memEnable1;
  assign memDataBus1 = (!memEnable1 && !memRead1) ? 16'hA5A5 : 16'hzzzz;

  sram_arbiter #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .reqA(reqA1), .weA(weA1), .addrA(addrA1), .wdataA(wdataA1), .ackA(ackA1), .rdataA(rdataA1),
    .reqB(reqB1), .addrB(addrB1), .ackB(ackB1), .rdataB(rdataB1),
    .reqV(reqV1), .addrV(addrV1), .ackV(ackV1), .rdataV(rdataV1),
    .owner(owner1), .memDataBus(memDataBus1), .memAddrBus(memAddrBus1),
    .memRead(memRead1), .memWrite(memWrite1), .memEnable(memEnable1)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int enLow = 0, rdLow = 0, wrLow = 0, dutDrv = 0, dut1234 = 0;
  int lastAckCyc = 0;
  int ackLog[$];
  logic [17:0] expQ[$];  // {port, rdata of that port at its ack}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pin activity counters and scoreboard comparison on each ack
  always @(negedge clk) begin
    logic [17:0] e;
    logic [1:0]  p;
    logic [15:0] rd;
    if (!memEnable) enLow++;
    if (!memRead)   rdLow++;
    if (!memWrite)  wrLow++;
    if (!modelDrv && (memDataBus !== 16'hzzzz)) begin
      dutDrv++;
      if (memDataBus === 16'h1234) dut1234++;
    end
    if (rst && (ackA || ackB || ackV)) begin
      lastAckCyc = cyc;
      ackLog.push_back(cyc);
      check("ack_onehot", 32'(ackA) + 32'(ackB) + 32'(ackV), 32'd1);
      p  = ackA ? 2'd1 : (ackB ? 2'd2 : 2'd3);
      rd = ackA ? rdataA : (ackB ? rdataB : rdataV);
      check("owner_at_ack", {30'd0, owner}, {30'd0, p});
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got port %0d expected none", p);
      end else begin
        e = expQ.pop_front();
        check("ack_port", {30'd0, p}, {30'd0, e[17:16]});
        check("ack_rdata", {16'd0, rd}, {16'd0, e[15:0]});
      end
    end
  end

  // Drop each request on the edge after its ack; bounded wait for all to finish
  task automatic waitDone(input int budget);
    int n;
    logic aA, aB, aV;
    n = 0;
    while ((reqA || reqB || reqV) && (n < budget)) begin
      @(negedge clk);
      aA = ackA; aB = ackB; aV = ackV;
      @(posedge clk);
      #1;
      if (aA) reqA = 1'b0;
      if (aB) reqB = 1'b0;
      if (aV) reqV = 1'b0;
      n++;
    end
    check("completion_in_budget", 32'(n < budget), 32'd1);
    reqA = 1'b0; reqB = 1'b0; reqV = 1'b0;
    check("scoreboard_drained", 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    int en0, rd0, wr0, drv0, d12340, st, n, d;
    logic gotV, got;
    rst = 1'b0;
    reqA = 1'b0; weA = 1'b0; reqB = 1'b0; reqV = 1'b0;
    addrA = 18'd0; addrB = 18'd0; addrV = 18'd0; wdataA = 16'd0;
    reqA1 = 1'b0; weA1 = 1'b0; reqB1 = 1'b0; reqV1 = 1'b0;
    addrA1 = 18'd0; addrB1 = 18'd0; addrV1 = 18'd0; wdataA1 = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_owner", {30'd0, owner}, 32'd0);
    check("rst_acks", {29'd0, ackA, ackB, ackV}, 32'd0);
    check("rst_rdata", {16'd0, rdataA | rdataB | rdataV}, 32'd0);
    check("rst_addr", {14'd0, memAddrBus}, 32'd0);
    check("rst_strobes", {29'd0, memRead, memWrite, memEnable}, 32'd7);
    check("rst_bus_z", 32'(memDataBus === 16'hzzzz), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // B read of preloaded 0xBEEF
    en0 = enLow; rd0 = rdLow; wr0 = wrLow; drv0 = dutDrv;
    addrB = 18'h00100; reqB = 1'b1; st = cyc;
    expQ.push_back({2'd2, 16'hBEEF});
    waitDone(20);
    check("bread_en_low", 32'(enLow - en0), 32'd3);
    check("bread_rd_low", 32'(rdLow - rd0), 32'd3);
    check("bread_wr_low", 32'(wrLow - wr0), 32'd0);
    check("bread_bus_undriven", 32'(dutDrv - drv0), 32'd0);
    check("bread_ack_latency", 32'(lastAckCyc - st), 32'd4);
    check("bread_rdata_held", {16'd0, rdataB}, 32'h0000BEEF);

    // A write to the top address; rdataA keeps its previous value
    en0 = enLow; rd0 = rdLow; wr0 = wrLow; drv0 = dutDrv; d12340 = dut1234;
    addrA = 18'h3FFFF; wdataA = 16'h1234; weA = 1'b1; reqA = 1'b1;
    expQ.push_back({2'd1, 16'h0000});
    waitDone(20);
    check("awrite_wr_low", 32'(wrLow - wr0), 32'd2);
    check("awrite_en_low", 32'(enLow - en0), 32'd3);
    check("awrite_rd_low", 32'(rdLow - rd0), 32'd0);
    check("awrite_bus_cycles", 32'(dut1234 - d12340), 32'd4);
    check("awrite_drv_cycles", 32'(dutDrv - drv0), 32'd4);
    check("awrite_bus_z_after", 32'(memDataBus === 16'hzzzz), 32'd1);

    // A read back
    weA = 1'b0; reqA = 1'b1;
    expQ.push_back({2'd1, 16'h1234});
    waitDone(20);
    check("aread_rdata", {16'd0, rdataA}, 32'h00001234);

    // Simultaneous A, B, V
    ackLog.delete();
    addrV = 18'h00200;
    reqA = 1'b1; reqB = 1'b1; reqV = 1'b1;
    expQ.push_back({2'd1, 16'h1234});
    expQ.push_back({2'd2, 16'hBEEF});
    expQ.push_back({2'd3, 16'hCAFE});
    waitDone(40);
    check("simul_ack_count", 32'(ackLog.size()), 32'd3);
    if (ackLog.size() == 3) begin
      check("simul_spacing_ab", 32'(ackLog[1] - ackLog[0]), 32'd5);
      check("simul_spacing_bv", 32'(ackLog[2] - ackLog[1]), 32'd5);
    end

    // Starvation: A and B always requesting, V granted on the 9th arbitration
    reqA = 1'b1; reqB = 1'b1; reqV = 1'b1;
    for (int i = 0; i < 8; i++) expQ.push_back({2'd1, 16'h1234});
    expQ.push_back({2'd3, 16'hCAFE});
    gotV = 1'b0; n = 0;
    while (!gotV && (n < 100)) begin
      @(negedge clk);
      gotV = ackV;
      n++;
    end
    @(posedge clk);
    #1;
    reqA = 1'b0; reqB = 1'b0; reqV = 1'b0;
    check("starve_v_granted", 32'(gotV), 32'd1);
    check("starve_queue_drained", 32'(expQ.size()), 32'd0);
    expQ.delete();

    // Cleared starvation count: A beats V again
    reqA = 1'b1; reqV = 1'b1;
    expQ.push_back({2'd1, 16'h1234});
    expQ.push_back({2'd3, 16'hCAFE});
    waitDone(40);

    // Reset in the middle of a write's ACCESS phase
    addrA = 18'h00300; wdataA = 16'h5555; weA = 1'b1; reqA = 1'b1;
    n = 0;
    while ((memWrite !== 1'b0) && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    check("rstmid_reached_access", 32'(n < 20), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rstmid_strobes", {29'd0, memRead, memWrite, memEnable}, 32'd7);
    check("rstmid_bus_z", 32'(memDataBus === 16'hzzzz), 32'd1);
    check("rstmid_owner", {30'd0, owner}, 32'd0);
    check("rstmid_addr", {14'd0, memAddrBus}, 32'd0);
    check("rstmid_rdata", {16'd0, rdataA | rdataB}, 32'd0);
    check("rstmid_ack", {31'd0, ackA}, 32'd0);
    reqA = 1'b0; weA = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Normal B read after reset
    reqB = 1'b1; st = cyc;
    expQ.push_back({2'd2, 16'hBEEF});
    waitDone(20);
    check("postrst_latency", 32'(lastAckCyc - st), 32'd4);

    // One-cycle access phase instance
    addrB1 = 18'h00005; reqB1 = 1'b1; st = cyc;
    got = 1'b0; n = 0; en0 = 0; rd0 = 0; d = 0;
    while (!got && (n < 20)) begin
      @(negedge clk);
      if (!memEnable1) en0++;
      if (!memRead1) rd0++;
      if (ackB1) begin
        got = 1'b1;
        d = cyc - st;
      end
      n++;
    end
    @(posedge clk);
    #1;
    reqB1 = 1'b0;
    check("w1_ack_seen", 32'(got), 32'd1);
    check("w1_ack_latency", 32'(d), 32'd3);
    check("w1_en_low", 32'(en0), 32'd2);
    check("w1_rd_low", 32'(rd0), 32'd2);
    check("w1_rdata", {16'd0, rdataB1}, 32'h0000A5A5);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
